// File: rtl/sync_fifo_ctrl_if.sv
// Write/read valid-ready handshake bundle for the synchronous FIFO controller.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_ctrl_if #(
  parameter int DW = 18
) ();
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO control: wrap-bit pointers, occupancy count, almost-full
// flag and clearable high-water mark. Storage is an external 2-port RAM with
// combinational read; this block only drives its address/data/enable.
module sync_fifo_ctrl #(
  parameter int DW           = 18,
  parameter int AW           = 7,
  parameter int AFULL_THRESH = 2**AW - 4
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_ctrl_if.slave bus,
  output logic [AW:0]   count,
  output logic          afull,
  output logic [AW:0]   hwm,
  input  logic          hwm_clr,
  output logic          ram_wen,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0] wr_ptr, rd_ptr, count_nxt;
  logic        push, pop;

  // Flags come straight from the registered count, so full blocks a push even
  // when a pop happens in the same cycle (and empty likewise blocks a pop).
  assign bus.in_rdy  = (count != FULL_CNT);
  assign bus.out_vld = (count != '0);

  // in_rdy reads 1 during reset, so reset must gate the handshake itself.
  assign push = bus.in_vld  & bus.in_rdy  & ~rst;
  assign pop  = bus.out_vld & bus.out_rdy & ~rst;

  assign ram_wen      = push;
  assign ram_wr_addr  = wr_ptr[AW-1:0];
  assign ram_wr_data  = bus.in_data;
  assign ram_rd_addr  = rd_ptr[AW-1:0];
  // rd_ptr only moves on a pop, so the head word is held while stalled.
  assign bus.out_data = ram_rd_data;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Pointers advance one entry per handshake and wrap through the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Occupancy, almost-full and high-water mark; a clear takes priority over
  // a new maximum and restarts tracking from the post-update count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      afull <= 1'b0;
      hwm   <= '0;
    end else begin
      count <= count_nxt;
      afull <= (count_nxt >= AF_CNT);
      if (hwm_clr)              hwm <= count_nxt;
      else if (count_nxt > hwm) hwm <= count_nxt;
    end
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized + directed bench for sync_fifo_ctrl with an internal RAM model,
// a queue-based reference model and a decoupled output monitor.
module tb_sync_fifo_ctrl;
  localparam int DW     = 18;
  localparam int AW     = 7;
  localparam int DEPTH  = 2**AW;
  localparam int THRESH = DEPTH - 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hwm_clr;
  logic [AW:0]   count, hwm;
  logic          afull;
  logic          ram_wen;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [DW-1:0] mem [DEPTH];

  sync_fifo_ctrl_if #(.DW(DW)) bus ();

  sync_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .count(count), .afull(afull), .hwm(hwm), .hwm_clr(hwm_clr),
    .ram_wen(ram_wen), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read, never cleared.
  always @(posedge clk) if (ram_wen) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: occupancy, write/read positions and hwm from the rules,
  // plus the scoreboard of words expected at the output in order.
  logic [DW-1:0] sb [$];
  int mcnt = 0, mhwm = 0, mwr = 0, mrd = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sb.delete();
        mcnt = 0; mhwm = 0; mwr = 0; mrd = 0;
      end else begin
        bit p, q;
        p = bus.in_vld  && (mcnt != DEPTH);
        q = bus.out_rdy && (mcnt != 0);
        if (p) sb.push_back(bus.in_data);
        mcnt = mcnt + int'(p) - int'(q);
        mwr  = (mwr + int'(p)) % DEPTH;
        mrd  = (mrd + int'(q)) % DEPTH;
        if (hwm_clr)          mhwm = mcnt;
        else if (mcnt > mhwm) mhwm = mcnt;
      end
    end
  end

  // Monitor: state checks every cycle, data popped from the scoreboard on
  // each DUT output handshake, and head stability while stalled.
  initial begin
    bit            hold_pend = 0;
    logic [DW-1:0] hold_val  = '0;
    forever begin
      @(negedge clk);
      if (rst) hold_pend = 0;
      else begin
        chk("count",   32'(count),   32'(mcnt));
        chk("out_vld", 32'(bus.out_vld), 32'(mcnt != 0));
        chk("in_rdy",  32'(bus.in_rdy),  32'(mcnt != DEPTH));
        chk("afull",   32'(afull),   32'(mcnt >= THRESH));
        chk("hwm",     32'(hwm),     32'(mhwm));
        chk("ram_wen", 32'(ram_wen), 32'(bus.in_vld && mcnt != DEPTH));
        chk("wr_addr", 32'(ram_wr_addr), 32'(mwr));
        chk("rd_addr", 32'(ram_rd_addr), 32'(mrd));
        if (hold_pend && bus.out_vld) chk("hold", 32'(bus.out_data), 32'(hold_val));
        hold_pend = bus.out_vld && !bus.out_rdy;
        hold_val  = bus.out_data;
        if (bus.out_vld && bus.out_rdy) begin
          if (sb.size() == 0) chk("sb_empty", 32'(bus.out_vld), 32'(0));
          else chk("data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_to(input int n);
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 300 && int'(count) != n; i++) begin
      bus.in_vld  = 1'b1;
      bus.in_data = DW'($urandom);
      step();
    end
    bus.in_vld = 1'b0;
    chk("fill_to", 32'(count), 32'(n));
  endtask

  task automatic drain();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 300 && bus.out_vld; i++) step();
    bus.out_rdy = 1'b0;
    chk("drain", 32'(count), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rst = 1'b1; hwm_clr = 1'b0;
    bus.in_vld = 1'b0; bus.out_rdy = 1'b0; bus.in_data = '0;
    #1;
    chk("rst_count",  32'(count), 0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 1);
    chk("rst_out_vld", 32'(bus.out_vld), 0);
    step(); step();
    rst = 1'b0;
    step();

    // Three back-to-back pushes, then in-order drain.
    for (int k = 1; k <= 3; k++) begin
      bus.in_vld = 1'b1; bus.in_data = DW'(k);
      step();
      chk("t1_vld", 32'(bus.out_vld), 1);
    end
    bus.in_vld = 1'b0;
    chk("t1_count", 32'(count), 3);
    chk("t1_head", 32'(bus.out_data), 1);
    bus.out_rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk("t1_out", 32'(bus.out_data), 32'(k));
      step();
    end
    bus.out_rdy = 1'b0;
    chk("t1_empty", 32'(count), 0);

    // Fill to full, afull threshold, pop-one recovery.
    fill_to(THRESH - 1);
    chk("t2_afull0", 32'(afull), 0);
    fill_to(THRESH);
    chk("t2_afull1", 32'(afull), 1);
    fill_to(DEPTH);
    chk("t2_full", 32'(bus.in_rdy), 0);
    bus.out_rdy = 1'b1; step(); bus.out_rdy = 1'b0;
    chk("t2_rdy_back", 32'(bus.in_rdy), 1);
    chk("t2_cnt127", 32'(count), DEPTH - 1);
    fill_to(DEPTH);

    // Full with push+pop: only the pop. Empty with push+pop: only the push.
    bus.in_vld = 1'b1; bus.out_rdy = 1'b1; bus.in_data = DW'($urandom);
    step();
    chk("t3_full_both", 32'(count), DEPTH - 1);
    drain();
    bus.in_vld = 1'b1; bus.out_rdy = 1'b1; bus.in_data = DW'($urandom);
    step();
    chk("t3_empty_both", 32'(count), 1);
    drain();

    // Steady stream through pointer wrap.
    fill_to(5);
    bus.in_vld = 1'b1; bus.out_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_data = DW'($urandom);
      step();
    end
    bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    chk("t4_count", 32'(count), 5);
    drain();

    // High-water mark and clear-with-push.
    hwm_clr = 1'b1; step(); hwm_clr = 1'b0;
    chk("t5_clr0", 32'(hwm), 0);
    fill_to(10);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) step();
    bus.out_rdy = 1'b0;
    chk("t5_hwm10", 32'(hwm), 10);
    hwm_clr = 1'b1; bus.in_vld = 1'b1; bus.in_data = DW'($urandom);
    step();
    hwm_clr = 1'b0; bus.in_vld = 1'b0;
    chk("t5_hwm3", 32'(hwm), 3);
    drain();

    // Random traffic at several load mixes.
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pr;
      pv = (ph == 0) ? 50 : (ph == 1) ? 80 : (ph == 2) ? 30 : 95;
      pr = (ph == 0) ? 50 : (ph == 1) ? 30 : (ph == 2) ? 80 : 95;
      for (int i = 0; i < 500; i++) begin
        bus.in_vld  = ($urandom_range(99) < pv);
        bus.out_rdy = ($urandom_range(99) < pr);
        bus.in_data = DW'($urandom);
        hwm_clr     = ($urandom_range(63) == 0);
        step();
      end
    end
    hwm_clr = 1'b0;
    drain();

    // Async reset mid-cycle at count=50, then no stale read-back.
    fill_to(50);
    @(negedge clk); #2;
    rst = 1'b1; bus.in_vld = 1'b1;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_out_vld", 32'(bus.out_vld), 0);
    chk("t6_in_rdy", 32'(bus.in_rdy), 1);
    chk("t6_afull", 32'(afull), 0);
    chk("t6_hwm", 32'(hwm), 0);
    chk("t6_wen", 32'(ram_wen), 0);
    step();
    bus.in_vld = 1'b0;
    rst = 1'b0;
    step();
    bus.in_vld = 1'b1; bus.in_data = 18'h2a5c3;
    step();
    bus.in_vld = 1'b0;
    chk("t6_new_cnt", 32'(count), 1);
    chk("t6_new_word", 32'(bus.out_data), 32'h2a5c3);
    drain();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
